// File: rtl/cim_xbar_tile_if.sv
// Request/response bundle between the conv-layer controller and one CIM
// crossbar tile: input-buffer and weight-row writes, the start/busy/done
// handshake and the addressed output-buffer read port.
interface cim_xbar_tile_if #(
  parameter int xbar_size     = 256,
  parameter int datatype_size = 4,
  parameter int addr_size     = $clog2(xbar_size)
) ();
  logic                     i_we;
  logic [addr_size-1:0]     i_wr_addr;
  logic [datatype_size-1:0] i_wr_data;
  logic                     i_w_we;
  logic [addr_size-1:0]     i_w_addr;
  logic [xbar_size-1:0]     i_w_data;
  logic                     i_start;
  logic                     o_busy;
  logic                     o_done;
  logic [addr_size-1:0]     i_rd_addr;
  logic [datatype_size-1:0] o_data;

  // Controller side drives requests, samples status and read data.
  modport master (
    output i_we, i_wr_addr, i_wr_data, i_w_we, i_w_addr, i_w_data,
           i_start, i_rd_addr,
    input  o_busy, o_done, o_data
  );

  // Tile side.
  modport slave (
    input  i_we, i_wr_addr, i_wr_data, i_w_we, i_w_addr, i_w_data,
           i_start, i_rd_addr,
    output o_busy, o_done, o_data
  );
endinterface

// File: rtl/cim_xbar_tile.sv
// One CIM crossbar tile: 1-bit cell weights, an input operand per row, a
// row-serial matrix-vector multiply into per-column accumulators, saturating
// commit into the output buffer, and a registered addressed read port.
module cim_xbar_tile #(
  parameter int xbar_size     = 256,
  parameter int datatype_size = 4,
  parameter int addr_size     = $clog2(xbar_size)
) (
  input  logic           clk,
  input  logic           rst,
  cim_xbar_tile_if.slave bus
);
  // Wide enough for xbar_size rows of full-scale operands.
  localparam int ACC_W = datatype_size + addr_size;
  localparam logic [ACC_W-1:0] SAT_MAX = ACC_W'((1 << datatype_size) - 1);
  localparam logic [addr_size-1:0] LAST_ROW = addr_size'(xbar_size - 1);

  typedef enum logic [1:0] {S_IDLE, S_COMPUTE, S_COMMIT} state_t;

  state_t                   state_q, state_d;
  logic [addr_size-1:0]     row_q, row_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     acc_clr, acc_en, commit;

  logic [datatype_size-1:0] ibuf_q [xbar_size];
  logic [xbar_size-1:0]     w_q    [xbar_size];
  logic [ACC_W-1:0]         acc_q  [xbar_size];
  logic [datatype_size-1:0] obuf_q [xbar_size];
  logic [datatype_size-1:0] data_q;

  logic                     idle;
  logic [xbar_size-1:0]     w_row;
  logic [ACC_W-1:0]         addend;

  // Writes only land while idle; a write sharing a cycle with i_start is
  // stored at that edge and so is seen by the first compute row.
  assign idle   = (state_q == S_IDLE);
  assign w_row  = w_q[row_q];
  assign addend = ACC_W'(ibuf_q[row_q]);

  // State, row counter and the registered busy/done status.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next state; busy covers compute and commit, done marks the commit cycle.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    acc_clr = 1'b0;
    acc_en  = 1'b0;
    commit  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.i_start) begin
          acc_clr = 1'b1;
          row_d   = '0;
          busy_d  = 1'b1;
          state_d = S_COMPUTE;
        end
      end
      S_COMPUTE: begin
        acc_en = 1'b1;
        row_d  = row_q + 1'b1;
        if (row_q == LAST_ROW) begin
          done_d  = 1'b1;
          state_d = S_COMMIT;
        end
      end
      S_COMMIT: begin
        commit  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Weight rows are deliberately not reset; they persist until reprogrammed.
  always_ff @(posedge clk) begin
    if (!rst && idle && bus.i_w_we) w_q[bus.i_w_addr] <= bus.i_w_data;
  end

  // Input buffer write port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < xbar_size; r++) ibuf_q[r] <= '0;
    end else if (idle && bus.i_we) begin
      ibuf_q[bus.i_wr_addr] <= bus.i_wr_data;
    end
  end

  // One row per cycle: every column whose cell is set adds that row's operand.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < xbar_size; c++) acc_q[c] <= '0;
    end else if (acc_clr) begin
      for (int c = 0; c < xbar_size; c++) acc_q[c] <= '0;
    end else if (acc_en) begin
      for (int c = 0; c < xbar_size; c++)
        if (w_row[c]) acc_q[c] <= acc_q[c] + addend;
    end
  end

  // Commit saturates each column to the output width rather than wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < xbar_size; c++) obuf_q[c] <= '0;
    end else if (commit) begin
      for (int c = 0; c < xbar_size; c++)
        obuf_q[c] <= (acc_q[c] > SAT_MAX) ? {datatype_size{1'b1}}
                                          : acc_q[c][datatype_size-1:0];
    end
  end

  // Registered read; a read in the commit cycle still sees the old entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) data_q <= '0;
    else     data_q <= obuf_q[bus.i_rd_addr];
  end

  assign bus.o_busy = busy_q;
  assign bus.o_done = done_q;
  assign bus.o_data = data_q;
endmodule
